fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting N_REQ writers ownership of one shared FIFO write port.
// Build with FIFO_ARB_BURST_EN defined for multi-word (MAX_BURST) grants, else single-word grants.
module fifo_wr_arbiter #(
  parameter int BUS_WIDTH = 16,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*BUS_WIDTH-1:0] req_data,
  input  logic                       full,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           ack,
  output logic                       wr_en,
  output logic [BUS_WIDTH-1:0]       bus_in,
  output logic [IW-1:0]              owner_id,
  output logic                       busy
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("fifo_wr_arbiter: N_REQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be in 1..15");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_owner_q, last_owner_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;

  logic             accept;
  logic             burst_last;
  logic             release_own;
  logic [N_REQ-1:0] others;

  // First set bit of r strictly after base, wrapping; base itself is checked last.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    base);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(base) + k) % N_REQ;
      if (!found && r[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IW'(N_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  assign burst_last = ((burst_cnt_q + 4'd1) == 4'(MAX_BURST));
`else
  assign burst_last = 1'b1;
`endif

  assign accept      = (state_q == S_OWN) && req[owner_q] && !full;
  assign release_own = (state_q == S_OWN) && (!req[owner_q] || (accept && burst_last));
  assign others      = req & ~(N_REQ'(1) << owner_q);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    grant_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d     = S_OWN;
          owner_d     = rr_pick(req, last_owner_q);
          burst_cnt_d = '0;
        end
      end
      S_OWN: begin
        if (accept && burst_cnt_q != 4'hF) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
        if (release_own) begin
          last_owner_d = owner_q;
          if (|others) begin
            owner_d     = rr_pick(others, owner_q);
            burst_cnt_d = '0;
          end else if (req[owner_q]) begin
            burst_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
            owner_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = '0;
      end
    endcase

    if (state_d == S_OWN) begin
      grant_d = N_REQ'(1) << owner_d;
    end
  end

  // Write path is purely combinational so reset or full suppress the write in the same cycle.
  always_comb begin
    ack    = grant_q & req & {N_REQ{!full && !rst}};
    wr_en  = |ack;
    bus_in = '0;
    if (state_q == S_OWN) begin
      bus_in = req_data[int'(owner_q)*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  assign grant    = grant_q;
  assign owner_id = owner_q;
  assign busy     = |grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter at default parameters (4 requesters, 16-bit bus).
module tb_fifo_wr_arbiter;

  logic        CLK = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic        full;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        wr_en;
  logic [15:0] bus_in;
  logic [1:0]  owner_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] dat [4];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] grant;
    logic [3:0] ack;
    logic [1:0] owner;
  } vec_t;

  vec_t vec [40];
  int   n_vec = 0;

  fifo_wr_arbiter dut (
    .CLK      (CLK),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .full     (full),
    .grant    (grant),
    .ack      (ack),
    .wr_en    (wr_en),
    .bus_in   (bus_in),
    .owner_id (owner_id),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic add(input logic r, input logic [3:0] q, input logic f,
                     input logic [3:0] g, input logic [3:0] a, input logic [1:0] o);
    vec[n_vec].rst   = r;
    vec[n_vec].req   = q;
    vec[n_vec].full  = f;
    vec[n_vec].grant = g;
    vec[n_vec].ack   = a;
    vec[n_vec].owner = o;
    n_vec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_bus;
    logic        seen;

    dat[0] = 16'hA000;
    dat[1] = 16'hB111;
    dat[2] = 16'hC222;
    dat[3] = 16'hD333;
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    rst  = 1'b1;
    req  = 4'b1111;
    full = 1'b0;

`ifndef FIFO_ARB_BURST_EN
    // rst   req      full grant    ack      owner
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 2'd0);
    add(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 2'd0);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 2'd0);
    add(1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0010, 2'd1);
    add(1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0100, 2'd2);
    add(1'b0, 4'b1111, 1'b0, 4'b1000, 4'b1000, 2'd3);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 2'd0);
    add(1'b0, 4'b0100, 1'b0, 4'b0010, 4'b0000, 2'd1);
    add(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 2'd2);
    add(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 2'd2);
    add(1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 2'd2);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 2'd2);
    add(1'b0, 4'b0010, 1'b0, 4'b0100, 4'b0000, 2'd2);
    add(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0010, 2'd1);
    add(1'b0, 4'b1000, 1'b0, 4'b0010, 4'b0000, 2'd1);
    add(1'b1, 4'b1000, 1'b0, 4'b1000, 4'b0000, 2'd3);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    add(1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 2'd0);
    add(1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 2'd2);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    add(1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 2'd0);
    add(1'b0, 4'b1001, 1'b0, 4'b1000, 4'b1000, 2'd3);
    add(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0001, 2'd0);
    add(1'b0, 4'b0000, 1'b0, 4'b1000, 4'b0000, 2'd3);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
`else
    add(1'b1, 4'b0011, 1'b0, 4'b0000, 4'b0000, 2'd0);
    add(1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 2'd0);
    for (int i = 0; i < 4; i++) add(1'b0, 4'b0011, 1'b0, 4'b0001, 4'b0001, 2'd0);
    for (int i = 0; i < 4; i++) add(1'b0, 4'b0011, 1'b0, 4'b0010, 4'b0010, 2'd1);
    add(1'b0, 4'b0011, 1'b0, 4'b0001, 4'b0001, 2'd0);
`endif

    for (int i = 0; i < n_vec; i++) begin
      @(negedge CLK);
      rst  = vec[i].rst;
      req  = vec[i].req;
      full = vec[i].full;
      #2;
      exp_bus = (vec[i].grant == 4'b0000) ? 16'h0000 : dat[vec[i].owner];
      check($sformatf("v%0d grant", i), 32'(grant), 32'(vec[i].grant));
      check($sformatf("v%0d ack", i), 32'(ack), 32'(vec[i].ack));
      check($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(|vec[i].ack));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(|vec[i].grant));
      check($sformatf("v%0d owner_id", i), 32'(owner_id), 32'(vec[i].owner));
      check($sformatf("v%0d bus_in", i), 32'(bus_in), 32'(exp_bus));
    end

    // Lone requester 0: bounded wait for its first write.
    @(negedge CLK);
    rst  = 1'b0;
    req  = 4'b0001;
    full = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      #2;
      if (ack[0]) seen = 1'b1;
      else @(negedge CLK);
    end
    check("wait ack0", 32'(seen), 32'd1);
    check("wait bus_in", 32'(bus_in), 32'(dat[0]));

    // Full stall on an owned grant, then resume.
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      full = 1'b1;
      #2;
      check($sformatf("stall%0d wr_en", c), 32'(wr_en), 32'd0);
      check($sformatf("stall%0d grant", c), 32'(grant), 32'h1);
    end
    @(negedge CLK);
    full = 1'b0;
    #2;
    check("resume ack", 32'(ack), 32'h1);
    check("resume wr_en", 32'(wr_en), 32'd1);

    // Reset while owning: write suppressed at once, grant gone after the edge.
    @(negedge CLK);
    rst = 1'b1;
    #2;
    check("rst wr_en", 32'(wr_en), 32'd0);
    @(negedge CLK);
    #2;
    check("rst grant", 32'(grant), 32'h0);
    check("rst busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
